// File: rtl/wb_arb_pkg.sv
// Shared types and constants for the two-master Wishbone arbiter.
package wb_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_G0   = 2'b01,
        ST_G1   = 2'b10
    } state_t;

    localparam logic [1:0] GNT_NONE = 2'b00;
    localparam logic [1:0] GNT_M0   = 2'b01;
    localparam logic [1:0] GNT_M1   = 2'b10;

    // One-hot grant vector for a given arbiter state.
    function automatic logic [1:0] gnt_of(input state_t s);
        logic [1:0] g;
        case (s)
            ST_G0:   g = GNT_M0;
            ST_G1:   g = GNT_M1;
            default: g = GNT_NONE;
        endcase
        return g;
    endfunction

endpackage

// File: rtl/wb_arb_wdog.sv
// Bus watchdog: counts strobed cycles without a slave response and pulses on expiry.
module wb_arb_wdog
    import wb_arb_pkg::*;
#(
    parameter int unsigned TIMEOUT = 255,
    parameter int unsigned TW      = 8
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic i_en,
    input  logic i_clr,
    output logic o_timeout_c
);

    localparam logic [TW-1:0] LIMIT   = TW'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);
    localparam logic [TW-1:0] CNT_MAX = '1;

    logic [TW-1:0] r_cnt;

    assign o_timeout_c = (TIMEOUT != 0) && i_en && (r_cnt == LIMIT);

    // Saturating counter; any interruption of the wait restarts it.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_cnt <= '0;
        end else if (i_clr || !i_en || o_timeout_c) begin
            r_cnt <= '0;
        end else if (r_cnt != CNT_MAX) begin
            r_cnt <= r_cnt + TW'(1);
        end
    end

endmodule

// File: rtl/wb_arb2_ctrl.sv
// Round-robin two-master to one-slave Wishbone arbiter with cycle-long grant lock
// and a watchdog that terminates stalled strobes with an error.
module wb_arb2_ctrl
    import wb_arb_pkg::*;
#(
    parameter int unsigned AW      = 32,
    parameter int unsigned DW      = 32,
    parameter int unsigned TIMEOUT = 255,
    parameter int unsigned TW      = 8
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic [DW-1:0]   m0_data_i,
    output logic [DW-1:0]   m0_data_o,
    input  logic [AW-1:0]   m0_addr_i,
    input  logic [DW/8-1:0] m0_sel_i,
    input  logic            m0_we_i,
    input  logic            m0_cyc_i,
    input  logic            m0_stb_i,
    output logic            m0_ack_o,
    output logic            m0_err_o,
    input  logic [DW-1:0]   m1_data_i,
    output logic [DW-1:0]   m1_data_o,
    input  logic [AW-1:0]   m1_addr_i,
    input  logic [DW/8-1:0] m1_sel_i,
    input  logic            m1_we_i,
    input  logic            m1_cyc_i,
    input  logic            m1_stb_i,
    output logic            m1_ack_o,
    output logic            m1_err_o,
    input  logic [DW-1:0]   s_data_i,
    output logic [DW-1:0]   s_data_o,
    output logic [AW-1:0]   s_addr_o,
    output logic [DW/8-1:0] s_sel_o,
    output logic            s_we_o,
    output logic            s_cyc_o,
    output logic            s_stb_o,
    input  logic            s_ack_i,
    input  logic            s_err_i,
    output logic [1:0]      grant_o
);

    state_t     r_state;
    state_t     w_next;
    state_t     w_arb;
    logic       r_last_m1;
    logic [1:0] r_grant;
    logic       w_own_stb;
    logic       w_wd_en;
    logic       w_wd_clr;
    logic       w_timeout;

    assign w_own_stb = ((r_state == ST_G0) && m0_stb_i) || ((r_state == ST_G1) && m1_stb_i);
    assign w_wd_en   = w_own_stb && !s_ack_i && !s_err_i;
    assign w_wd_clr  = (w_next != r_state);
    assign grant_o   = r_grant;

    wb_arb_wdog #(
        .TIMEOUT (TIMEOUT),
        .TW      (TW)
    ) u_wdog (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .i_en        (w_wd_en),
        .i_clr       (w_wd_clr),
        .o_timeout_c (w_timeout)
    );

    // State, grant and round-robin history; last_grant starts at m1 so m0 wins the first tie.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_state   <= ST_IDLE;
            r_grant   <= GNT_NONE;
            r_last_m1 <= 1'b1;
        end else begin
            r_state <= w_next;
            r_grant <= gnt_of(w_next);
            if ((w_next != r_state) && (w_next != ST_IDLE)) begin
                r_last_m1 <= (w_next == ST_G1);
            end
        end
    end

    // Arbitration, lock-while-cyc, and owner-routed datapath.
    always_comb begin
        w_arb     = ST_IDLE;
        w_next    = ST_IDLE;
        s_data_o  = '0;
        s_addr_o  = '0;
        s_sel_o   = '0;
        s_we_o    = 1'b0;
        s_cyc_o   = 1'b0;
        s_stb_o   = 1'b0;
        m0_ack_o  = 1'b0;
        m0_err_o  = 1'b0;
        m1_ack_o  = 1'b0;
        m1_err_o  = 1'b0;
        m0_data_o = s_data_i;
        m1_data_o = s_data_i;

        if (m0_cyc_i && m1_cyc_i) begin
            w_arb = r_last_m1 ? ST_G0 : ST_G1;
        end else if (m0_cyc_i) begin
            w_arb = ST_G0;
        end else if (m1_cyc_i) begin
            w_arb = ST_G1;
        end

        case (r_state)
            ST_G0: begin
                w_next   = m0_cyc_i ? ST_G0 : w_arb;
                s_data_o = m0_data_i;
                s_addr_o = m0_addr_i;
                s_sel_o  = m0_sel_i;
                s_we_o   = m0_we_i;
                s_cyc_o  = m0_cyc_i;
                s_stb_o  = m0_stb_i && !w_timeout;
                m0_ack_o = s_ack_i;
                m0_err_o = s_err_i || w_timeout;
            end
            ST_G1: begin
                w_next   = m1_cyc_i ? ST_G1 : w_arb;
                s_data_o = m1_data_i;
                s_addr_o = m1_addr_i;
                s_sel_o  = m1_sel_i;
                s_we_o   = m1_we_i;
                s_cyc_o  = m1_cyc_i;
                s_stb_o  = m1_stb_i && !w_timeout;
                m1_ack_o = s_ack_i;
                m1_err_o = s_err_i || w_timeout;
            end
            default: begin
                w_next = w_arb;
            end
        endcase
    end

endmodule

// File: tb/tb_wb_arb2_ctrl.sv
// Directed bench for wb_arb2_ctrl; master responses are checked against a scoreboard queue.
module tb_wb_arb2_ctrl;

    logic        clk;
    logic        rst_n;
    logic [31:0] m0_data_i, m0_data_o, m0_addr_i;
    logic [3:0]  m0_sel_i;
    logic        m0_we_i, m0_cyc_i, m0_stb_i, m0_ack_o, m0_err_o;
    logic [31:0] m1_data_i, m1_data_o, m1_addr_i;
    logic [3:0]  m1_sel_i;
    logic        m1_we_i, m1_cyc_i, m1_stb_i, m1_ack_o, m1_err_o;
    logic [31:0] s_data_i, s_data_o, s_addr_o;
    logic [3:0]  s_sel_o;
    logic        s_we_o, s_cyc_o, s_stb_o, s_ack_i, s_err_i;
    logic [1:0]  grant_o;

    int checks   = 0;
    int failures = 0;

    // Response vector layout: {m0_ack, m0_err, m1_ack, m1_err}
    typedef struct {
        logic [3:0]  vec;
        logic [31:0] data;
    } exp_t;
    exp_t sb_q[$];

    wb_arb2_ctrl #(.AW(32), .DW(32), .TIMEOUT(4), .TW(3)) dut (
        .clk_i(clk), .rst_i(rst_n),
        .m0_data_i(m0_data_i), .m0_data_o(m0_data_o), .m0_addr_i(m0_addr_i),
        .m0_sel_i(m0_sel_i), .m0_we_i(m0_we_i), .m0_cyc_i(m0_cyc_i), .m0_stb_i(m0_stb_i),
        .m0_ack_o(m0_ack_o), .m0_err_o(m0_err_o),
        .m1_data_i(m1_data_i), .m1_data_o(m1_data_o), .m1_addr_i(m1_addr_i),
        .m1_sel_i(m1_sel_i), .m1_we_i(m1_we_i), .m1_cyc_i(m1_cyc_i), .m1_stb_i(m1_stb_i),
        .m1_ack_o(m1_ack_o), .m1_err_o(m1_err_o),
        .s_data_i(s_data_i), .s_data_o(s_data_o), .s_addr_o(s_addr_o), .s_sel_o(s_sel_o),
        .s_we_o(s_we_o), .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o),
        .s_ack_i(s_ack_i), .s_err_i(s_err_i), .grant_o(grant_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [3:0] vec, input logic [31:0] data);
        exp_t e;
        e.vec  = vec;
        e.data = data;
        sb_q.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard monitor: every master response must match the head of the queue.
    always @(negedge clk) begin : mon
        logic [3:0] v;
        exp_t       e;
        if (rst_n) begin
            v = {m0_ack_o, m0_err_o, m1_ack_o, m1_err_o};
            if (sb_q.size() == 0) begin
                if (v != 4'b0000) chk("sb_unexpected_resp", 64'(v), 64'd0);
            end else begin
                e = sb_q.pop_front();
                chk("sb_resp_vec", 64'(v), 64'(e.vec));
                if (e.vec[3:2] != 2'b00) chk("sb_m0_data", 64'(m0_data_o), 64'(e.data));
                else                     chk("sb_m1_data", 64'(m1_data_o), 64'(e.data));
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL global_timeout");
        $fatal(1, "bench did not finish");
    end

    initial begin
        rst_n = 1'b0;
        m0_data_i = '0; m0_addr_i = '0; m0_sel_i = 4'hF; m0_we_i = 1'b0; m0_cyc_i = 1'b0; m0_stb_i = 1'b0;
        m1_data_i = '0; m1_addr_i = '0; m1_sel_i = 4'hF; m1_we_i = 1'b0; m1_cyc_i = 1'b0; m1_stb_i = 1'b0;
        s_data_i = '0; s_ack_i = 1'b0; s_err_i = 1'b0;

        // Reset state
        @(negedge clk);
        chk("rst_grant", 64'(grant_o), 64'd0);
        chk("rst_s_cyc", 64'(s_cyc_o), 64'd0);
        chk("rst_s_stb", 64'(s_stb_o), 64'd0);
        chk("rst_m0_ack", 64'(m0_ack_o), 64'd0);
        tick();
        rst_n = 1'b1;
        tick();

        // Single request from m0, slave acks two cycles after cyc
        m0_cyc_i = 1'b1; m0_stb_i = 1'b1; m0_addr_i = 32'h0000_0010; m0_we_i = 1'b0;
        @(negedge clk);
        chk("t1_grant_before_edge", 64'(grant_o), 64'd0);
        tick();
        @(negedge clk);
        chk("t1_grant", 64'(grant_o), 64'h1);
        chk("t1_s_addr", 64'(s_addr_o), 64'h10);
        chk("t1_s_cycstb", 64'({s_cyc_o, s_stb_o, s_we_o}), 64'b110);
        tick();
        s_ack_i = 1'b1; s_data_i = 32'hDEAD_BEEF;
        push(4'b1000, 32'hDEAD_BEEF);
        @(negedge clk);
        chk("t1_m1_ack_quiet", 64'(m1_ack_o), 64'd0);
        tick();
        s_ack_i = 1'b0; m0_cyc_i = 1'b0; m0_stb_i = 1'b0;
        tick();

        // Tie from reset: m0 first, then direct handoff to m1
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        m0_cyc_i = 1'b1; m0_stb_i = 1'b1; m0_addr_i = 32'h100;
        m1_cyc_i = 1'b1; m1_stb_i = 1'b1; m1_addr_i = 32'h200;
        tick();
        s_ack_i = 1'b1; s_data_i = 32'h11;
        push(4'b1000, 32'h11);
        @(negedge clk);
        chk("t2_tie_m0", 64'(grant_o), 64'h1);
        chk("t2_addr_m0", 64'(s_addr_o), 64'h100);
        tick();
        s_ack_i = 1'b0; m0_cyc_i = 1'b0; m0_stb_i = 1'b0;
        @(negedge clk);
        chk("t2_hold", 64'(grant_o), 64'h1);
        tick();
        s_ack_i = 1'b1; s_data_i = 32'h22;
        push(4'b0010, 32'h22);
        @(negedge clk);
        chk("t2_handoff", 64'(grant_o), 64'h2);
        chk("t2_addr_m1", 64'(s_addr_o), 64'h200);
        tick();
        s_ack_i = 1'b0; m1_cyc_i = 1'b0; m1_stb_i = 1'b0;
        tick();

        // Round-robin: both keep requesting, owner drops cyc after each ack
        m0_cyc_i = 1'b1; m0_stb_i = 1'b1; m1_cyc_i = 1'b1; m1_stb_i = 1'b1;
        tick();
        for (int i = 0; i < 4; i++) begin
            logic own_m1;
            own_m1 = i[0];
            s_ack_i = 1'b1; s_data_i = 32'hA0 + 32'(i);
            push(own_m1 ? 4'b0010 : 4'b1000, 32'hA0 + 32'(i));
            @(negedge clk);
            chk($sformatf("t3_rr_grant%0d", i), 64'(grant_o), own_m1 ? 64'h2 : 64'h1);
            tick();
            s_ack_i = 1'b0;
            if (own_m1) begin m1_cyc_i = 1'b0; m1_stb_i = 1'b0; end
            else        begin m0_cyc_i = 1'b0; m0_stb_i = 1'b0; end
            tick();
            if (own_m1) begin m1_cyc_i = 1'b1; m1_stb_i = 1'b1; end
            else        begin m0_cyc_i = 1'b1; m0_stb_i = 1'b1; end
        end
        m0_cyc_i = 1'b0; m0_stb_i = 1'b0; m1_cyc_i = 1'b0; m1_stb_i = 1'b0;
        tick();

        // Lock: m1 does three back-to-back acked writes while m0 waits
        m1_cyc_i = 1'b1; m1_stb_i = 1'b1; m1_we_i = 1'b1; m1_sel_i = 4'b0011;
        m1_data_i = 32'h1234_5678; m1_addr_i = 32'h300;
        tick();
        m0_cyc_i = 1'b1; m0_stb_i = 1'b1; m0_addr_i = 32'h10;
        s_ack_i = 1'b1; s_data_i = 32'h0;
        for (int i = 0; i < 3; i++) begin
            push(4'b0010, 32'h0);
            @(negedge clk);
            chk($sformatf("t4_lock_grant%0d", i), 64'(grant_o), 64'h2);
            chk($sformatf("t4_sel%0d", i), 64'(s_sel_o), 64'b0011);
            chk($sformatf("t4_wdata%0d", i), 64'(s_data_o), 64'h1234_5678);
            chk($sformatf("t4_we%0d", i), 64'(s_we_o), 64'd1);
            tick();
        end
        s_ack_i = 1'b0; m1_cyc_i = 1'b0; m1_stb_i = 1'b0; m1_we_i = 1'b0; m1_sel_i = 4'hF;
        @(negedge clk);
        chk("t4_still_m1", 64'(grant_o), 64'h2);
        tick();
        s_ack_i = 1'b1; s_data_i = 32'h33;
        push(4'b1000, 32'h33);
        @(negedge clk);
        chk("t4_m0_after", 64'(grant_o), 64'h1);
        tick();
        s_ack_i = 1'b0; m0_cyc_i = 1'b0; m0_stb_i = 1'b0;
        tick();

        // Watchdog: no response for 4 strobed cycles, then ack exactly on the 4th
        m0_cyc_i = 1'b1; m0_stb_i = 1'b1; m0_addr_i = 32'h400; s_data_i = 32'h0;
        tick();
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            chk($sformatf("t5_stb_wait%0d", k), 64'(s_stb_o), 64'd1);
            tick();
        end
        push(4'b0100, 32'h0);
        @(negedge clk);
        chk("t5_stb_forced_low", 64'(s_stb_o), 64'd0);
        tick();
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            chk($sformatf("t5_stb_rewait%0d", k), 64'(s_stb_o), 64'd1);
            tick();
        end
        s_ack_i = 1'b1; s_data_i = 32'hA5A5_A5A5;
        push(4'b1000, 32'hA5A5_A5A5);
        @(negedge clk);
        chk("t5_ack_wins_stb", 64'(s_stb_o), 64'd1);
        tick();
        s_ack_i = 1'b0; m0_cyc_i = 1'b0; m0_stb_i = 1'b0;
        tick();

        // Reset in the middle of an m1 transfer
        m1_cyc_i = 1'b1; m1_stb_i = 1'b1; m1_addr_i = 32'h500;
        tick();
        @(negedge clk);
        chk("t6_g1", 64'(grant_o), 64'h2);
        chk("t6_stb_before", 64'(s_stb_o), 64'd1);
        #2;
        rst_n = 1'b0; s_ack_i = 1'b1;
        #1;
        chk("t6_cyc_drop", 64'(s_cyc_o), 64'd0);
        chk("t6_stb_drop", 64'(s_stb_o), 64'd0);
        chk("t6_grant_drop", 64'(grant_o), 64'd0);
        chk("t6_no_ack", 64'(m1_ack_o), 64'd0);
        s_ack_i = 1'b0;
        m0_cyc_i = 1'b1; m0_stb_i = 1'b1;
        tick();
        rst_n = 1'b1;
        @(negedge clk);
        chk("t6_grant_pre", 64'(grant_o), 64'd0);
        tick();
        @(negedge clk);
        chk("t6_m0_first", 64'(grant_o), 64'h1);
        tick();
        m0_cyc_i = 1'b0; m0_stb_i = 1'b0; m1_cyc_i = 1'b0; m1_stb_i = 1'b0;
        tick();
        @(negedge clk);
        chk("sb_drained", 64'(sb_q.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
